// File: rtl/counter_with_enable_pkg.sv
// counter_with_enable_pkg: shared constants for counter_with_enable (default width, reset-active level)
package counter_with_enable_pkg;
  localparam int COUNTER_WIDTH_DEFAULT = 8;
  localparam logic RESET_ACTIVE = 1'b0;
endpackage

// File: rtl/counter_with_enable_next.sv
// counter_with_enable_next: next-count logic; count,enable in, next_count out; wraps, or saturates when COUNTER_WITH_ENABLE_SATURATE_EN is defined
module counter_with_enable_next
  import counter_with_enable_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  output logic [WIDTH-1:0] next_count
);
`ifdef COUNTER_WITH_ENABLE_SATURATE_EN
  always_comb next_count = (enable && count != '1) ? count + WIDTH'(1) : count;
`else
  always_comb next_count = enable ? count + WIDTH'(1) : count;
`endif
endmodule

// File: rtl/counter_with_enable.sv
// counter_with_enable: registered up-counter; count out, enable in, clk, reset (sync active-low); saturating build via COUNTER_WITH_ENABLE_SATURATE_EN
module counter_with_enable
  import counter_with_enable_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             clk,
  input  logic             reset
);
  logic [WIDTH-1:0] next_count;
  counter_with_enable_next #(.WIDTH(WIDTH)) u_next (
    .count(count),
    .enable(enable),
    .next_count(next_count)
  );
  always_ff @(posedge clk) count <= (reset == RESET_ACTIVE) ? '0 : next_count;
endmodule

// File: tb/tb_counter_with_enable.sv
// tb_counter_with_enable: scoreboard bench for counter_with_enable with directed vectors
module tb_counter_with_enable;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [W-1:0] count;
  logic [W-1:0] exp_q[$];
  string name_q[$];
  int passed = 0;
  int total = 0;
  counter_with_enable #(.WIDTH(W)) dut (
    .count(count),
    .enable(enable),
    .clk(clk),
    .reset(reset)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic e, input logic [W-1:0] x, input string n);
    @(negedge clk);
    reset = r;
    enable = e;
    exp_q.push_back(x);
    name_q.push_back(n);
    @(posedge clk);
  endtask
  initial begin : monitor
    logic [W-1:0] x;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (count === x) passed++;
        else $display("FAIL %s: count=%h expected=%h", n, count, x);
      end
    end
  end
  initial begin : stim
    logic [W-1:0] e;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, "powerup_reset");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, "idle_hold");
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, W'(i), "count_up");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "reset_wins");
    step(1'b1, 1'b1, 8'h01, "resume_after_reset");
    step(1'b1, 1'b0, 8'h01, "hold_after_resume");
    step(1'b0, 1'b0, 8'h00, "reset_before_wrap");
    for (int i = 1; i <= 258; i++) begin
`ifdef COUNTER_WITH_ENABLE_SATURATE_EN
      e = (i > 255) ? 8'hFF : W'(i);
      step(1'b1, 1'b1, e, "saturate");
`else
      e = W'(i % 256);
      step(1'b1, 1'b1, e, "wrap");
`endif
    end
    step(1'b0, 1'b1, 8'h00, "reset_from_top");
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, W'(i), "count_to_5");
    step(1'b1, 1'b1, 8'h06, "toggle_en1");
    step(1'b1, 1'b0, 8'h06, "toggle_en0");
    step(1'b1, 1'b1, 8'h07, "toggle_en1b");
    step(1'b1, 1'b0, 8'h07, "toggle_en0b");
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
